// File: rtl/csr_seq_ctrl.sv
// rtl/csr_seq_ctrl.sv - Zicsr RMW and trap-entry sequencer owning the CSR file port.
// Optional MRET sequence enabled by macro CSR_SEQ_MRET_EN.
module csr_seq_ctrl #(
    parameter int XLEN         = 64,
    parameter int MTVEC_VEC_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      priv_lvl,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [1:0]      op_type,
    input  logic            op_nowr,
    input  logic [11:0]     op_addr,
    input  logic [XLEN-1:0] op_src,
    output logic            op_done,
    output logic [XLEN-1:0] op_rd_data,
    output logic            op_illegal,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic [XLEN-1:0] trap_pc,
    output logic            trap_done,
    output logic [XLEN-1:0] trap_vector,
    output logic [11:0]     csr_addr,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      csr_priv,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_illegal,
    output logic            busy
`ifdef CSR_SEQ_MRET_EN
    ,
    input  logic            mret_valid,
    output logic            mret_done,
    output logic [XLEN-1:0] ret_pc
`endif
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        S_IDLE, S_OP_RD, S_OP_WR, S_OP_DONE,
        S_TR_EPC, S_TR_CAUSE, S_TR_TVAL, S_TR_MSR, S_TR_MSW, S_TR_VEC, S_TR_DONE
`ifdef CSR_SEQ_MRET_EN
        , S_MR_RD, S_MR_WR, S_MR_PC, S_MR_DONE
`endif
    } state_t;

    state_t          state;
    logic            csr_we_q;
    logic [1:0]      typ_q;
    logic            nowr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] old_q;
    logic [1:0]      priv_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] op_wval;
    logic [XLEN-1:0] ms_trap;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] vec_val;
    logic            in_trap;
    logic            op_blocked;

    assign in_trap  = (state inside {S_TR_EPC, S_TR_CAUSE, S_TR_TVAL, S_TR_MSR,
                                     S_TR_MSW, S_TR_VEC, S_TR_DONE});
    assign csr_priv = in_trap ? 2'b11 : priv_lvl;
    // Write strobe is cut in the reset cycle itself so an aborted sequence never lands.
    assign csr_we   = csr_we_q & ~rst;
    assign busy     = (state != S_IDLE);

`ifdef CSR_SEQ_MRET_EN
    assign op_blocked = trap_valid | mret_valid;
`else
    assign op_blocked = trap_valid;
`endif
    assign trap_ready = (state == S_IDLE);
    assign op_ready   = (state == S_IDLE) & ~op_blocked;

    always_comb begin
        case (typ_q)
            2'b01:   op_wval = src_q;
            2'b11:   op_wval = csr_rdata & ~src_q;
            default: op_wval = csr_rdata | src_q;
        endcase
        ms_trap        = csr_rdata;
        ms_trap[7]     = csr_rdata[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = priv_q;
        mtvec_base     = {csr_rdata[XLEN-1:2], 2'b00};
        vec_val        = mtvec_base;
        if ((MTVEC_VEC_EN != 0) && (csr_rdata[1:0] == 2'b01) && cause_q[XLEN-1])
            vec_val = mtvec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
    end

`ifdef CSR_SEQ_MRET_EN
    logic [XLEN-1:0] ms_mret;
    always_comb begin
        ms_mret        = csr_rdata;
        ms_mret[3]     = csr_rdata[7];
        ms_mret[7]     = 1'b1;
        ms_mret[12:11] = 2'b00;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            csr_addr    <= '0;
            csr_we_q    <= 1'b0;
            csr_wdata   <= '0;
            op_done     <= 1'b0;
            op_rd_data  <= '0;
            op_illegal  <= 1'b0;
            trap_done   <= 1'b0;
            trap_vector <= '0;
            typ_q       <= '0;
            nowr_q      <= 1'b0;
            src_q       <= '0;
            old_q       <= '0;
            priv_q      <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
`ifdef CSR_SEQ_MRET_EN
            mret_done   <= 1'b0;
            ret_pc      <= '0;
`endif
        end else begin
            op_done   <= 1'b0;
            trap_done <= 1'b0;
            csr_we_q  <= 1'b0;
`ifdef CSR_SEQ_MRET_EN
            mret_done <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (trap_valid) begin
                        state     <= S_TR_EPC;
                        priv_q    <= priv_lvl;
                        cause_q   <= trap_cause;
                        tval_q    <= trap_tval;
                        csr_addr  <= A_MEPC;
                        csr_we_q  <= 1'b1;
                        csr_wdata <= trap_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`ifdef CSR_SEQ_MRET_EN
                    end else if (mret_valid) begin
                        // Non-M-mode MRET completes immediately with no CSR side effects.
                        if (priv_lvl == 2'b11) begin
                            state    <= S_MR_RD;
                            csr_addr <= A_MSTATUS;
                        end else begin
                            state     <= S_MR_DONE;
                            mret_done <= 1'b1;
                            ret_pc    <= '0;
                        end
`endif
                    end else if (op_valid) begin
                        state    <= S_OP_RD;
                        typ_q    <= op_type;
                        nowr_q   <= op_nowr;
                        src_q    <= op_src;
                        csr_addr <= op_addr;
                    end
                end
                S_OP_RD: begin
                    if (csr_illegal) begin
                        state      <= S_OP_DONE;
                        op_done    <= 1'b1;
                        op_illegal <= 1'b1;
                        op_rd_data <= '0;
                    end else if (nowr_q && (typ_q != 2'b01)) begin
                        state      <= S_OP_DONE;
                        op_done    <= 1'b1;
                        op_illegal <= 1'b0;
                        op_rd_data <= csr_rdata;
                    end else begin
                        state     <= S_OP_WR;
                        csr_we_q  <= 1'b1;
                        csr_wdata <= op_wval;
                        old_q     <= csr_rdata;
                    end
                end
                S_OP_WR: begin
                    state      <= S_OP_DONE;
                    op_done    <= 1'b1;
                    op_illegal <= 1'b0;
                    op_rd_data <= old_q;
                end
                S_TR_EPC: begin
                    state     <= S_TR_CAUSE;
                    csr_addr  <= A_MCAUSE;
                    csr_we_q  <= 1'b1;
                    csr_wdata <= cause_q;
                end
                S_TR_CAUSE: begin
                    state     <= S_TR_TVAL;
                    csr_addr  <= A_MTVAL;
                    csr_we_q  <= 1'b1;
                    csr_wdata <= tval_q;
                end
                S_TR_TVAL: begin
                    state    <= S_TR_MSR;
                    csr_addr <= A_MSTATUS;
                end
                S_TR_MSR: begin
                    state     <= S_TR_MSW;
                    csr_we_q  <= 1'b1;
                    csr_wdata <= ms_trap;
                end
                S_TR_MSW: begin
                    state    <= S_TR_VEC;
                    csr_addr <= A_MTVEC;
                end
                S_TR_VEC: begin
                    state       <= S_TR_DONE;
                    trap_done   <= 1'b1;
                    trap_vector <= vec_val;
                end
`ifdef CSR_SEQ_MRET_EN
                S_MR_RD: begin
                    state     <= S_MR_WR;
                    csr_we_q  <= 1'b1;
                    csr_wdata <= ms_mret;
                end
                S_MR_WR: begin
                    state    <= S_MR_PC;
                    csr_addr <= A_MEPC;
                end
                S_MR_PC: begin
                    state     <= S_MR_DONE;
                    mret_done <= 1'b1;
                    ret_pc    <= csr_rdata;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// tb/tb_csr_seq_ctrl.sv - directed self-checking bench for csr_seq_ctrl with a behavioural CSR file.
module tb_csr_seq_ctrl;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      priv_lvl = 2'b11;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [1:0]      op_type = 2'b00;
    logic            op_nowr = 1'b0;
    logic [11:0]     op_addr = '0;
    logic [XLEN-1:0] op_src = '0;
    logic            op_done;
    logic [XLEN-1:0] op_rd_data;
    logic            op_illegal;
    logic            trap_valid = 1'b0;
    logic            trap_ready;
    logic [XLEN-1:0] trap_cause = '0;
    logic [XLEN-1:0] trap_tval = '0;
    logic [XLEN-1:0] trap_pc = '0;
    logic            trap_done;
    logic [XLEN-1:0] trap_vector;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [1:0]      csr_priv;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            busy;

    logic [XLEN-1:0] csrf [0:4095];
    logic            poke_en = 1'b0;
    logic [11:0]     poke_addr = '0;
    logic [XLEN-1:0] poke_data = '0;

    int checks = 0;
    int failures = 0;

    csr_seq_ctrl #(.XLEN(XLEN), .MTVEC_VEC_EN(1)) dut (
        .clk(clk), .rst(rst), .priv_lvl(priv_lvl),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .op_nowr(op_nowr),
        .op_addr(op_addr), .op_src(op_src), .op_done(op_done), .op_rd_data(op_rd_data),
        .op_illegal(op_illegal),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_pc(trap_pc), .trap_done(trap_done),
        .trap_vector(trap_vector),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_priv(csr_priv),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, privilege taken from address bits [9:8].
    assign csr_rdata   = csrf[csr_addr];
    assign csr_illegal = (csr_priv < csr_addr[9:8]);

    always @(posedge clk) begin
        if (csr_we) csrf[csr_addr] <= csr_wdata;
        else if (poke_en) csrf[poke_addr] <= poke_data;
    end

    task automatic poke(input logic [11:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_op(output int lat, output int nwe, output logic [XLEN-1:0] rd, output logic ill);
        lat = 0; nwe = 0; rd = '0; ill = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (csr_we) nwe++;
            if (op_done) begin lat = k; rd = op_rd_data; ill = op_illegal; break; end
        end
    endtask

    task automatic run_op(input logic [1:0] t, input logic nw, input logic [11:0] a,
                          input logic [XLEN-1:0] s, output int lat, output int nwe,
                          output logic [XLEN-1:0] rd, output logic ill);
        @(negedge clk);
        op_valid = 1'b1; op_type = t; op_nowr = nw; op_addr = a; op_src = s;
        @(posedge clk);
        #1 op_valid = 1'b0;
        wait_op(lat, nwe, rd, ill);
    endtask

    task automatic run_trap(input logic [XLEN-1:0] c, input logic [XLEN-1:0] tv,
                            input logic [XLEN-1:0] p, input logic with_op,
                            output logic opr, output int lat, output int nwe, output logic prv_ok);
        @(negedge clk);
        trap_valid = 1'b1; trap_cause = c; trap_tval = tv; trap_pc = p;
        if (with_op) op_valid = 1'b1;
        #1 opr = op_ready;
        @(posedge clk);
        #1 trap_valid = 1'b0;
        lat = 0; nwe = 0; prv_ok = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (csr_we) nwe++;
            if (csr_priv !== 2'b11) prv_ok = 1'b0;
            if (trap_done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", csr_we); end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (op_ready !== 1'b1 || trap_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", op_ready, trap_ready); end
        checks++; if (op_done !== 1'b0 || trap_done !== 1'b0 || op_illegal !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", op_done, trap_done, op_illegal); end
        checks++; if (op_rd_data !== '0 || trap_vector !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", op_rd_data, trap_vector); end
    endtask

    task automatic test_op_rs();
        int lat, nwe; logic [XLEN-1:0] rd; logic ill;
        priv_lvl = 2'b11;
        poke(12'h340, 64'h5);
        run_op(2'b10, 1'b0, 12'h340, 64'hA0, lat, nwe, rd, ill);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rs_latency got=%0d exp=3", lat); end
        checks++; if (nwe !== 1) begin failures++; $display("FAIL rs_writes got=%0d exp=1", nwe); end
        checks++; if (rd !== 64'h5 || ill !== 1'b0) begin failures++; $display("FAIL rs_rd got=%h ill=%b exp=5 ill=0", rd, ill); end
        checks++; if (csrf[12'h340] !== 64'hA5) begin failures++; $display("FAIL rs_mscratch got=%h exp=a5", csrf[12'h340]); end
        @(negedge clk);
        checks++; if (op_done !== 1'b0 || op_rd_data !== 64'h5) begin failures++; $display("FAIL rs_hold got=%b/%h exp=0/5", op_done, op_rd_data); end
    endtask

    task automatic test_op_nowr();
        int lat, nwe; logic [XLEN-1:0] rd; logic ill;
        run_op(2'b11, 1'b1, 12'h340, 64'hFF, lat, nwe, rd, ill);
        checks++; if (lat !== 2) begin failures++; $display("FAIL nowr_latency got=%0d exp=2", lat); end
        checks++; if (nwe !== 0) begin failures++; $display("FAIL nowr_writes got=%0d exp=0", nwe); end
        checks++; if (rd !== 64'hA5) begin failures++; $display("FAIL nowr_rd got=%h exp=a5", rd); end
        checks++; if (csrf[12'h340] !== 64'hA5) begin failures++; $display("FAIL nowr_mscratch got=%h exp=a5", csrf[12'h340]); end
    endtask

    task automatic test_op_rw_rc();
        int lat, nwe; logic [XLEN-1:0] rd; logic ill;
        run_op(2'b01, 1'b1, 12'h340, 64'h123, lat, nwe, rd, ill);
        checks++; if (lat !== 3 || nwe !== 1) begin failures++; $display("FAIL rw_nowr got lat=%0d we=%0d exp=3/1", lat, nwe); end
        checks++; if (rd !== 64'hA5 || csrf[12'h340] !== 64'h123) begin failures++; $display("FAIL rw_data got=%h/%h exp=a5/123", rd, csrf[12'h340]); end
        run_op(2'b11, 1'b0, 12'h340, 64'h3, lat, nwe, rd, ill);
        checks++; if (rd !== 64'h123 || csrf[12'h340] !== 64'h120) begin failures++; $display("FAIL rc_data got=%h/%h exp=123/120", rd, csrf[12'h340]); end
        run_op(2'b00, 1'b0, 12'h340, 64'h1000, lat, nwe, rd, ill);
        checks++; if (rd !== 64'h120 || csrf[12'h340] !== 64'h1120) begin failures++; $display("FAIL type00_data got=%h/%h exp=120/1120", rd, csrf[12'h340]); end
    endtask

    task automatic test_illegal();
        int lat, nwe; logic [XLEN-1:0] rd; logic ill;
        poke(12'h300, 64'h8);
        priv_lvl = 2'b00;
        run_op(2'b01, 1'b0, 12'h300, 64'hFFFF, lat, nwe, rd, ill);
        checks++; if (ill !== 1'b1 || rd !== '0) begin failures++; $display("FAIL illegal_flag got ill=%b rd=%h exp ill=1 rd=0", ill, rd); end
        checks++; if (lat !== 2 || nwe !== 0) begin failures++; $display("FAIL illegal_timing got lat=%0d we=%0d exp=2/0", lat, nwe); end
        checks++; if (csrf[12'h300] !== 64'h8) begin failures++; $display("FAIL illegal_mstatus got=%h exp=8", csrf[12'h300]); end
    endtask

    task automatic test_trap_priority();
        logic opr, pok, ill; int lat, nwe, olat, onwe; logic [XLEN-1:0] rd;
        poke(12'h305, 64'h1000);
        priv_lvl = 2'b00;
        op_type = 2'b10; op_nowr = 1'b0; op_addr = 12'h340; op_src = 64'h10;
        run_trap(64'd2, 64'hDEAD, 64'h8000_0006, 1'b1, opr, lat, nwe, pok);
        checks++; if (opr !== 1'b0) begin failures++; $display("FAIL prio_op_ready got=%b exp=0", opr); end
        checks++; if (lat !== 7 || nwe !== 4) begin failures++; $display("FAIL prio_trap_timing got lat=%0d we=%0d exp=7/4", lat, nwe); end
        checks++; if (pok !== 1'b1) begin failures++; $display("FAIL prio_csr_priv got=%b exp=1", pok); end
        checks++; if (csrf[12'h300] !== 64'h80) begin failures++; $display("FAIL prio_mstatus got=%h exp=80", csrf[12'h300]); end
        checks++; if (csrf[12'h341] !== 64'h8000_0004 || csrf[12'h342] !== 64'd2 || csrf[12'h343] !== 64'hDEAD) begin failures++; $display("FAIL prio_epc_cause_tval got=%h/%h/%h exp=80000004/2/dead", csrf[12'h341], csrf[12'h342], csrf[12'h343]); end
        checks++; if (trap_vector !== 64'h1000) begin failures++; $display("FAIL prio_vector got=%h exp=1000", trap_vector); end
        priv_lvl = 2'b11;
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL prio_op_resume got=%b exp=1", op_ready); end
        @(posedge clk);
        #1 op_valid = 1'b0;
        wait_op(olat, onwe, rd, ill);
        checks++; if (olat !== 3 || rd !== 64'h1120 || csrf[12'h340] !== 64'h1130) begin failures++; $display("FAIL prio_op_after got lat=%0d rd=%h ms=%h exp=3/1120/1130", olat, rd, csrf[12'h340]); end
        checks++; if (trap_vector !== 64'h1000) begin failures++; $display("FAIL prio_vector_hold got=%h exp=1000", trap_vector); end
    endtask

    task automatic test_vectored();
        logic opr, pok; int lat, nwe;
        priv_lvl = 2'b11;
        poke(12'h305, 64'h2001);
        run_trap(64'h8000_0000_0000_0007, 64'h0, 64'h400, 1'b0, opr, lat, nwe, pok);
        checks++; if (trap_vector !== 64'h201C) begin failures++; $display("FAIL vec_mode1 got=%h exp=201c", trap_vector); end
        checks++; if (csrf[12'h300] !== 64'h1800) begin failures++; $display("FAIL vec_mstatus got=%h exp=1800", csrf[12'h300]); end
        poke(12'h305, 64'h3002);
        run_trap(64'h8000_0000_0000_0007, 64'h0, 64'h400, 1'b0, opr, lat, nwe, pok);
        checks++; if (trap_vector !== 64'h3000) begin failures++; $display("FAIL vec_mode2 got=%h exp=3000", trap_vector); end
        poke(12'h305, 64'h2001);
        run_trap(64'h7, 64'h0, 64'h400, 1'b0, opr, lat, nwe, pok);
        checks++; if (trap_vector !== 64'h2000) begin failures++; $display("FAIL vec_sync got=%h exp=2000", trap_vector); end
    endtask

    task automatic test_reset_mid_trap();
        int nwe, ndone;
        poke(12'h342, 64'h55);
        poke(12'h343, 64'h77);
        @(negedge clk);
        trap_valid = 1'b1; trap_cause = 64'h9; trap_tval = 64'h99; trap_pc = 64'h1237;
        @(posedge clk);
        #1 trap_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", csr_we); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || trap_ready !== 1'b1) begin failures++; $display("FAIL rstmid_idle got busy=%b rdy=%b exp=0/1", busy, trap_ready); end
        nwe = 0; ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (csr_we) nwe++;
            if (trap_done) ndone++;
            @(negedge clk);
        end
        checks++; if (nwe !== 0 || ndone !== 0) begin failures++; $display("FAIL rstmid_quiet got we=%0d done=%0d exp=0/0", nwe, ndone); end
        checks++; if (csrf[12'h343] !== 64'h77 || csrf[12'h342] !== 64'h55) begin failures++; $display("FAIL rstmid_regs got tval=%h cause=%h exp=77/55", csrf[12'h343], csrf[12'h342]); end
        checks++; if (csrf[12'h341] !== 64'h1234) begin failures++; $display("FAIL rstmid_mepc got=%h exp=1234", csrf[12'h341]); end
    endtask

    initial begin
        test_reset();
        test_op_rs();
        test_op_nowr();
        test_op_rw_rc();
        test_illegal();
        test_trap_priority();
        test_vectored();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_seq_ctrl.md
Name: csr_seq_ctrl

Overview:
Sequencer sitting between decode/execute and the machine CSR file. It owns the CSR file's single address/write port, and arbitrates between two requesters:
- Zicsr instructions (CSRRW/CSRRS/CSRRC as atomic read-modify-write).
- Trap-entry requests (multi-cycle writes of mepc/mcause/mtval/mstatus, then mtvec read to produce the handler PC).

Parameters:
XLEN, 64, data width
MTVEC_VEC_EN, 1, 1 = honour vectored mtvec mode (mode 1); 0 = always direct

Ports:
clk  in  1  clock
rst  in  1  reset
priv_lvl  in  2  current privilege (0 U, 1 S, 3 M)
op_valid  in  1  CSR instruction request
op_ready  out  1  request accepted this cycle
op_type  in  2  01 RW, 10 RS, 11 RC (00 treated as RS)
op_nowr  in  1  suppress write (rs1=x0 / zimm=0 for RS/RC)
op_addr  in  12  CSR address
op_src  in  XLEN  rs1 value or zero-extended zimm
op_done  out  1  one-cycle completion pulse
op_rd_data  out  XLEN  old CSR value for rd
op_illegal  out  1  valid with op_done; access illegal
trap_valid  in  1  trap-entry request
trap_ready  out  1  trap request accepted
trap_cause  in  XLEN  mcause value
trap_tval  in  XLEN  mtval value
trap_pc  in  XLEN  faulting PC for mepc
trap_done  out  1  one-cycle pulse
trap_vector  out  XLEN  handler PC, valid with trap_done
csr_addr  out  12  to CSR file
csr_we  out  1  to CSR file
csr_wdata  out  XLEN  to CSR file
csr_priv  out  2  privilege presented to CSR file
csr_rdata  in  XLEN  combinational read data
csr_illegal  in  1  combinational illegal flag
busy  out  1  state != IDLE

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset: state IDLE. All outputs 0 except op_ready and trap_ready, which follow IDLE rules.
- Reset asserted mid-sequence: abort, csr_we=0 in the reset cycle, no done pulse.

IDLE:
- trap_ready=1, op_ready=~trap_valid. Trap has priority on simultaneous requests.
- Request fields are latched on accept.
- csr_priv=priv_lvl when idle or running an op; 2'b11 throughout a trap sequence.

Op path (accept at T):
- RD (T+1): csr_addr=op_addr, we=0. Sample csr_rdata into old and csr_illegal.
  - csr_illegal=1 -> DONE with op_illegal=1, no write.
  - op_nowr=1 and type!=RW -> DONE.
  - Otherwise -> WR.
- WR (T+2): we=1, wdata = src (RW), old|src (RS), or old&~src (RC).
- DONE: op_done=1 for one cycle. op_rd_data=old, held until the next accept.
- Latency: 3 cycles with a write, 2 without.
- op_illegal=1 forces op_rd_data=0.

Trap path (accept at T), one write per cycle:
- T+1: 0x341 <= trap_pc with bits[1:0] cleared.
- T+2: 0x342 <= cause.
- T+3: 0x343 <= tval.
- T+4: read 0x300.
- T+5: write 0x300 with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=latched priv, all other bits unchanged.
- T+6: read 0x305.
  - If MTVEC_VEC_EN, mtvec[1:0]==01 and cause[63]=1: vector = base + 4*cause[5:0].
  - Otherwise: vector = base, where base = {mtvec[63:2],2'b00}.
  - mtvec[1:0] of 10/11 is treated as direct.
- T+7: trap_done=1. trap_vector held until next trap accept.

Other rules:
- Requests arriving while busy are not accepted; requesters hold valid.
- csr_illegal is ignored on trap-path writes.

Optional Feature:
Macro CSR_SEQ_MRET_EN.

With the macro defined:
- Extra ports: mret_valid in 1, mret_done out 1, ret_pc out XLEN.
- Priority: trap > mret > op.
- Sequence:
  - Read 0x300.
  - Write 0x300 with MIE=MPIE, MPIE=1, MPP=00.
  - Read 0x341 into ret_pc.
  - Pulse mret_done (accept to done = 4 cycles).
- mret_valid with priv_lvl!=3 is accepted and completes as mret_done with ret_pc=0 and no writes.

Without the macro: ports absent, no MRET states.

Test Plan:
- M-mode, mscratch=0x5, CSRRS 0x340 src=0xA0 -> op_rd_data=0x5, op_done at T+3, mscratch=0xA5.
- CSRRC 0x340 op_nowr=1 -> no csr_we cycle, op_done at T+2, mscratch unchanged.
- U-mode CSRRW 0x300 -> op_illegal=1, op_rd_data=0, no write, mstatus unchanged.
- trap_valid and op_valid in the same cycle; mstatus=0x8, priv=0, cause=2, mtvec=0x1000 -> op_ready=0, trap_done at T+7, mstatus=0x80, mepc=pc, vector=0x1000; the op then completes.
- mtvec=0x2001, cause=0x8000000000000007 -> vector=0x201C (0x2000 if MTVEC_VEC_EN=0).
- rst pulsed at trap T+2 -> no further writes, mtval unchanged, no trap_done, IDLE next cycle.
